// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor, A - B computed one bit per clock as
// A + ~B + 1 through a single full-adder cell with a registered carry.
module serial_sub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovfl
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_sr_q,   a_sr_d;
    logic [WIDTH-1:0] b_sr_q,   b_sr_d;
    logic [WIDTH-1:0] res_q,    res_d;
    logic             carry_q,  carry_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic             amsb_q,   amsb_d;
    logic             bmsb_q,   bmsb_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             borrow_q, borrow_d;
    logic             ovfl_q,   ovfl_d;

    // Full-adder cell: LSB of A, inverted LSB of B, running carry.
    logic a_bit, nb_bit, sum_bit, carry_nxt;
    assign a_bit     = a_sr_q[0];
    assign nb_bit    = ~b_sr_q[0];
    assign sum_bit   = a_bit ^ nb_bit ^ carry_q;
    assign carry_nxt = (a_bit & nb_bit) | (a_bit & carry_q) | (nb_bit & carry_q);

    // Next-state logic: operand load, per-bit shift, result publish on the last bit.
    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_d    = res_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        amsb_d   = amsb_q;
        bmsb_d   = bmsb_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovfl_d   = ovfl_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_SHIFT;
                    a_sr_d  = A;
                    b_sr_d  = B;
                    amsb_d  = A[WIDTH-1];
                    bmsb_d  = B[WIDTH-1];
                    carry_d = 1'b1;          // the +1 of two's complement
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                // start is deliberately ignored here; operands are already captured
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                res_d   = {sum_bit, res_q[WIDTH-1:1]};
                carry_d = carry_nxt;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d  = S_DONE;
                    diff_d   = {sum_bit, res_q[WIDTH-1:1]};
                    borrow_d = ~carry_nxt;
                    ovfl_d   = (amsb_q != bmsb_q) && (sum_bit != amsb_q);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_q    <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            amsb_q   <= 1'b0;
            bmsb_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovfl_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_q    <= res_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            amsb_q   <= amsb_d;
            bmsb_q   <= bmsb_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovfl_q   <= ovfl_d;
        end
    end

    assign busy   = (state_q == S_SHIFT);
    assign done   = (state_q == S_DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign ovfl   = ovfl_q;

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: directed vectors for serial_sub at WIDTH=16.
module tb_serial_sub;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         busy, done, borrow, ovfl;
    logic [W-1:0] diff;

    int total = 0;
    int bad   = 0;

    serial_sub #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .busy(busy), .done(done), .diff(diff), .borrow(borrow), .ovfl(ovfl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge: present operands with start for one edge, then scramble A/B.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = W'($urandom); B = W'($urandom);
    endtask

    // Called at the negedge after the accepting edge; returns at the DONE negedge.
    task automatic wait_done(input string tag, input logic [W-1:0] ed,
                             input logic eb, input logic eo);
        int edges = 1;
        int busy_n = 0;
        logic [W-1:0] d0 = diff;
        logic moved = 1'b0;
        while (!done && edges < 40) begin
            if (busy) busy_n++;
            if (diff !== d0) moved = 1'b1;
            A = W'($urandom); B = W'($urandom);
            @(negedge clk);
            edges++;
        end
        chk({tag, ".done"},    32'(done),   32'd1);
        chk({tag, ".lat"},     32'(edges),  32'd17);
        chk({tag, ".busyn"},   32'(busy_n), 32'd16);
        chk({tag, ".hold"},    32'(moved),  32'd0);
        chk({tag, ".diff"},    32'(diff),   32'(ed));
        chk({tag, ".borrow"},  32'(borrow), 32'(eb));
        chk({tag, ".ovfl"},    32'(ovfl),   32'(eo));
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ed, input logic eb, input logic eo);
        @(negedge clk);
        launch(a, b);
        wait_done(tag, ed, eb, eo);
        @(negedge clk);
        chk({tag, ".pulse"}, 32'(done), 32'd0);
        chk({tag, ".idle"},  32'(busy), 32'd0);
        chk({tag, ".keep"},  32'(diff), 32'(ed));
    endtask

    initial begin
        int extra;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst.busy",   32'(busy),   32'd0);
        chk("rst.done",   32'(done),   32'd0);
        chk("rst.diff",   32'(diff),   32'd0);
        chk("rst.borrow", 32'(borrow), 32'd0);
        chk("rst.ovfl",   32'(ovfl),   32'd0);

        run_op("v5m3",   16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0);
        run_op("v3m5",   16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0);
        run_op("vmin",   16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1);
        run_op("vmax",   16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1);
        run_op("veq",    16'hABCD, 16'hABCD, 16'h0000, 1'b0, 1'b0);
        run_op("vb0",    16'h1357, 16'h0000, 16'h1357, 1'b0, 1'b0);
        run_op("v0m1",   16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0);
        run_op("v8m7",   16'h8000, 16'h7FFF, 16'h0001, 1'b0, 1'b1);

        // back-to-back: new start issued in the DONE cycle
        @(negedge clk);
        launch(16'h0100, 16'h0001);
        wait_done("b2b1", 16'h00FF, 1'b0, 1'b0);
        launch(16'h0001, 16'h0002);
        wait_done("b2b2", 16'hFFFF, 1'b1, 1'b0);
        @(negedge clk);
        chk("b2b.pulse", 32'(done), 32'd0);

        // start during SHIFT is ignored, operands toggled in flight
        @(negedge clk);
        A = 16'h1234; B = 16'h0034; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            int edges = 1;
            int ndone = 0;
            while (!done && edges < 40) begin
                if (edges == 5) begin
                    A = 16'hFFFF; B = 16'hFFFF; start = 1'b1;
                end else begin
                    start = 1'b0;
                    A = ~A; B = B ^ 16'h5A5A;
                end
                @(negedge clk);
                edges++;
            end
            start = 1'b0;
            chk("ign.done", 32'(done),  32'd1);
            chk("ign.lat",  32'(edges), 32'd17);
            chk("ign.diff", 32'(diff),  32'h1200);
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (done) ndone++;
            end
            chk("ign.single", 32'(ndone), 32'd0);
        end

        // reset mid-SHIFT aborts with no done
        @(negedge clk);
        launch(16'h5555, 16'h1111);
        repeat (7) @(negedge clk);
        chk("abt.busy8", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abt.busy",   32'(busy),   32'd0);
        chk("abt.done",   32'(done),   32'd0);
        chk("abt.diff",   32'(diff),   32'd0);
        chk("abt.borrow", 32'(borrow), 32'd0);
        chk("abt.ovfl",   32'(ovfl),   32'd0);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        chk("abt.quiet", 32'(extra), 32'd0);
        run_op("post", 16'h0010, 16'h0001, 16'h000F, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
